// File: rtl/snake_pkg.sv
// Shared types for the plot command path between the game control FSM and the cell plotter.
package snake_pkg;

   localparam int unsigned GRID_W   = 4;
   localparam int unsigned COLOUR_W = 3;

   typedef struct packed {
      logic [GRID_W-1:0]   x;
      logic [GRID_W-1:0]   y;
      logic [COLOUR_W-1:0] colour;
   } plot_cmd_t;

   typedef enum logic {
      StIdle,
      StIssue
   } dn_state_e;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO of plot commands with a separate occupancy counter so full/empty never alias.
module cmd_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter type         entry_t = snake_pkg::plot_cmd_t,
   localparam int unsigned AW = $clog2(DEPTH),
   localparam int unsigned CW = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic          flush,
   input  entry_t        wdata,
   output entry_t        head,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty
);

   entry_t          mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            do_push, do_pop;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push & ~full & ~flush;
   assign do_pop  = pop & ~empty & ~flush;
   assign head    = mem_q[rd_ptr_q];
   assign count   = count_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         if (do_push && !do_pop)      count_d = count_q + CW'(1);
         else if (!do_push && do_pop) count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: count gates every read.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/plot_cmd_queue.sv
// Buffers plot commands from the control FSM and re-issues them in order to the cell plotter.
module plot_cmd_queue #(
   parameter int unsigned DEPTH    = 8,
   parameter int unsigned COLOUR_W = 3,
   localparam int unsigned CW      = $clog2(DEPTH) + 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        cmd_plot,
   input  logic [snake_pkg::GRID_W-1:0] cmd_x,
   input  logic [snake_pkg::GRID_W-1:0] cmd_y,
   input  logic [COLOUR_W-1:0]         cmd_colour,
   output logic                        cmd_waitrequest,
   input  logic                        flush,
   output logic                        dn_plot,
   output logic [snake_pkg::GRID_W-1:0] dn_x,
   output logic [snake_pkg::GRID_W-1:0] dn_y,
   output logic [COLOUR_W-1:0]         dn_colour,
   input  logic                        dn_waitrequest,
   output logic [CW-1:0]               count,
   output logic                        busy
);

   import snake_pkg::GRID_W;
   import snake_pkg::dn_state_e;
   import snake_pkg::StIdle;
   import snake_pkg::StIssue;

   typedef struct packed {
      logic [GRID_W-1:0]   x;
      logic [GRID_W-1:0]   y;
      logic [COLOUR_W-1:0] colour;
   } cmd_t;

   dn_state_e state_q, state_d;
   cmd_t      dn_cmd_q, dn_cmd_d;
   logic      dn_plot_q, dn_plot_d;
   cmd_t      wr_cmd, head;
   logic      accept, pop, full, empty;

   // Full comes from the registered count only, so no path from dn_waitrequest.
   assign cmd_waitrequest = rst | flush | full;
   assign accept          = cmd_plot & ~cmd_waitrequest;
   assign wr_cmd          = '{x: cmd_x, y: cmd_y, colour: cmd_colour};

   cmd_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (cmd_t)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (accept),
      .pop   (pop),
      .flush (flush),
      .wdata (wr_cmd),
      .head  (head),
      .count (count),
      .full  (full),
      .empty (empty)
   );

   always_comb begin
      state_d   = state_q;
      dn_cmd_d  = dn_cmd_q;
      dn_plot_d = dn_plot_q;
      pop       = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (!empty && !flush) begin
               pop       = 1'b1;
               dn_cmd_d  = head;
               dn_plot_d = 1'b1;
               state_d   = StIssue;
            end
         end
         StIssue: begin
            if (!dn_waitrequest) begin
               if (!empty && !flush) begin
                  pop      = 1'b1;
                  dn_cmd_d = head;
               end else begin
                  dn_plot_d = 1'b0;
                  state_d   = StIdle;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         dn_cmd_q  <= '0;
         dn_plot_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         dn_cmd_q  <= dn_cmd_d;
         dn_plot_q <= dn_plot_d;
      end
   end

   assign dn_plot   = dn_plot_q;
   assign dn_x      = dn_cmd_q.x;
   assign dn_y      = dn_cmd_q.y;
   assign dn_colour = dn_cmd_q.colour;
   assign busy      = (count != '0) | (state_q == StIssue);

endmodule

// File: tb/tb_plot_cmd_queue.sv
// Bench for plot_cmd_queue: vector table, directed corner sequences, then random traffic vs a queue model.
module tb_plot_cmd_queue;

   localparam int unsigned DEPTH = 8;
   localparam int unsigned CW    = 4;

   logic          clk = 1'b0;
   logic          rst, cmd_plot, flush, dn_waitrequest;
   logic [3:0]    cmd_x, cmd_y, dn_x, dn_y;
   logic [2:0]    cmd_colour, dn_colour;
   logic          cmd_waitrequest, dn_plot, busy;
   logic [CW-1:0] count;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   plot_cmd_queue #(
      .DEPTH    (DEPTH),
      .COLOUR_W (3)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .cmd_plot        (cmd_plot),
      .cmd_x           (cmd_x),
      .cmd_y           (cmd_y),
      .cmd_colour      (cmd_colour),
      .cmd_waitrequest (cmd_waitrequest),
      .flush           (flush),
      .dn_plot         (dn_plot),
      .dn_x            (dn_x),
      .dn_y            (dn_y),
      .dn_colour       (dn_colour),
      .dn_waitrequest  (dn_waitrequest),
      .count           (count),
      .busy            (busy)
   );

   // Reference model: a queue of waiting commands plus one in-flight slot.
   typedef struct packed {
      logic [3:0] x;
      logic [3:0] y;
      logic [2:0] c;
   } mcmd_t;

   mcmd_t mq[$];
   mcmd_t m_inf;
   bit    m_inf_v;

   bit         last_acc, last_dn_acc;
   logic [3:0] last_dn_x;

   typedef struct {
      bit         p;
      logic [3:0] x, y;
      logic [2:0] c;
      bit         fl, dw;
      bit         e_plot;
      logic [3:0] e_x, e_y;
      logic [2:0] e_c;
      logic [3:0] e_cnt;
      bit         e_wreq, e_busy;
   } vec_t;

   vec_t tbl[13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_inf_v = 1'b0;
   endtask

   task automatic model_check();
      bit mw;
      mw = flush || (mq.size() == DEPTH);
      chk("cmd_waitrequest", cmd_waitrequest, mw);
      chk("dn_plot", dn_plot, m_inf_v);
      chk("count", count, mq.size());
      chk("busy", busy, (mq.size() != 0) || m_inf_v);
      if (m_inf_v) begin
         chk("dn_x", dn_x, m_inf.x);
         chk("dn_y", dn_y, m_inf.y);
         chk("dn_colour", dn_colour, m_inf.c);
      end
   endtask

   task automatic model_step(input bit p, input mcmd_t c, input bit fl, input bit dw);
      bit acc;
      acc = p && !(fl || mq.size() == DEPTH);
      if (m_inf_v && dw) begin
         // stalled command stays put
      end else if (mq.size() != 0 && !fl) begin
         m_inf   = mq.pop_front();
         m_inf_v = 1'b1;
      end else begin
         m_inf_v = 1'b0;
      end
      if (fl) mq.delete();
      else if (acc) mq.push_back(c);
   endtask

   task automatic drive(input bit p, input logic [3:0] x, input logic [3:0] y,
                        input logic [2:0] c, input bit fl, input bit dw);
      cmd_plot       = p;
      cmd_x          = x;
      cmd_y          = y;
      cmd_colour     = c;
      flush          = fl;
      dn_waitrequest = dw;
   endtask

   task automatic tick(input bit p, input logic [3:0] x, input logic [3:0] y,
                       input logic [2:0] c, input bit fl, input bit dw);
      mcmd_t mc;
      drive(p, x, y, c, fl, dw);
      #1;
      model_check();
      last_acc    = p && !cmd_waitrequest;
      last_dn_acc = dn_plot && !dw;
      last_dn_x   = dn_x;
      mc = '{x: x, y: y, c: c};
      @(posedge clk);
      model_step(p, mc, fl, dw);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int    n_acc, drained, gaps;
      bit    pend_v;
      mcmd_t pend;
      vec_t  v;

      //          p  x     y     c       fl dw  plot e_x   e_y    e_c     cnt   wreq busy
      tbl[0]  = '{1, 4'd1, 4'd1, 3'b100, 0, 0,  0, 4'd0, 4'd0,  3'd0,   4'd0, 0, 0};
      tbl[1]  = '{0, 4'd0, 4'd0, 3'd0,   0, 0,  0, 4'd0, 4'd0,  3'd0,   4'd1, 0, 1};
      tbl[2]  = '{0, 4'd0, 4'd0, 3'd0,   0, 0,  1, 4'd1, 4'd1,  3'b100, 4'd0, 0, 1};
      tbl[3]  = '{0, 4'd0, 4'd0, 3'd0,   0, 0,  0, 4'd0, 4'd0,  3'd0,   4'd0, 0, 0};
      tbl[4]  = '{1, 4'd9, 4'd10, 3'b001, 0, 1, 0, 4'd0, 4'd0,  3'd0,   4'd0, 0, 0};
      tbl[5]  = '{0, 4'd0, 4'd0, 3'd0,   0, 1,  0, 4'd0, 4'd0,  3'd0,   4'd1, 0, 1};
      for (int i = 6; i <= 10; i++)
         tbl[i] = '{0, 4'd0, 4'd0, 3'd0, 0, 1,  1, 4'd9, 4'd10, 3'b001, 4'd0, 0, 1};
      tbl[11] = '{0, 4'd0, 4'd0, 3'd0,   0, 0,  1, 4'd9, 4'd10, 3'b001, 4'd0, 0, 1};
      tbl[12] = '{0, 4'd0, 4'd0, 3'd0,   0, 0,  0, 4'd0, 4'd0,  3'd0,   4'd0, 0, 0};

      // Reset held for three cycles
      rst = 1'b1;
      drive(0, 4'd0, 4'd0, 3'd0, 0, 0);
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_wreq", cmd_waitrequest, 1);
      chk("rst_dn_plot", dn_plot, 0);
      chk("rst_count", count, 0);
      chk("rst_busy", busy, 0);
      rst = 1'b0;
      #1;
      chk("post_rst_wreq", cmd_waitrequest, 0);
      @(negedge clk);

      // Vector table: single command latency and stall hold
      for (int i = 0; i < 13; i++) begin
         mcmd_t mc;
         v = tbl[i];
         drive(v.p, v.x, v.y, v.c, v.fl, v.dw);
         #1;
         chk($sformatf("vec%0d_plot", i), dn_plot, v.e_plot);
         chk($sformatf("vec%0d_count", i), count, v.e_cnt);
         chk($sformatf("vec%0d_wreq", i), cmd_waitrequest, v.e_wreq);
         chk($sformatf("vec%0d_busy", i), busy, v.e_busy);
         if (v.e_plot) begin
            chk($sformatf("vec%0d_x", i), dn_x, v.e_x);
            chk($sformatf("vec%0d_y", i), dn_y, v.e_y);
            chk($sformatf("vec%0d_colour", i), dn_colour, v.e_c);
         end
         mc = '{x: v.x, y: v.y, c: v.c};
         @(posedge clk);
         model_step(v.p, mc, v.fl, v.dw);
         @(negedge clk);
      end

      // Fill: 1 in flight + DEPTH queued, tenth command held off
      n_acc = 0;
      for (int k = 0; k < 20 && n_acc < 10; k++) begin
         tick(1, n_acc[3:0], 4'd2, 3'd5, 0, 1);
         if (last_acc) n_acc++;
      end
      chk("fill_accepted", n_acc, 9);
      chk("fill_count", count, 8);
      chk("fill_wreq", cmd_waitrequest, 1);
      chk("fill_inflight_x", dn_x, 0);

      // Drain: strict order, one per cycle, no gaps
      drained = 0;
      gaps    = 0;
      for (int k = 0; k < 30 && drained < 10; k++) begin
         tick(n_acc < 10, n_acc[3:0], 4'd2, 3'd5, 0, 0);
         if (last_acc) n_acc++;
         if (last_dn_acc) begin
            chk("drain_order", last_dn_x, drained);
            drained++;
         end else if (drained > 0) begin
            gaps++;
         end
      end
      chk("drain_total", drained, 10);
      chk("drain_gaps", gaps, 0);
      repeat (2) tick(0, 4'd0, 4'd0, 3'd0, 0, 0);

      // Simultaneous push and pop at count 3
      for (int k = 0; k < 4; k++) tick(1, 4'd10 + 4'(k), 4'd3, 3'd2, 0, 1);
      chk("pp_count_before", count, 3);
      tick(1, 4'd14, 4'd3, 3'd2, 0, 0);
      chk("pp_count_after", count, 3);
      chk("pp_inflight_x", dn_x, 11);
      repeat (6) tick(0, 4'd0, 4'd0, 3'd0, 0, 0);

      // Flush with four queued and one in flight, push during flush ignored
      for (int k = 0; k < 5; k++) tick(1, 4'd1 + 4'(k), 4'd7, 3'd6, 0, 1);
      chk("fl_count_before", count, 4);
      tick(1, 4'd15, 4'd15, 3'd7, 1, 1);
      chk("fl_count_after", count, 0);
      chk("fl_inflight_held", dn_plot, 1);
      chk("fl_inflight_x", dn_x, 1);
      repeat (2) tick(0, 4'd0, 4'd0, 3'd0, 0, 1);
      tick(0, 4'd0, 4'd0, 3'd0, 0, 0);
      repeat (3) tick(0, 4'd0, 4'd0, 3'd0, 0, 0);
      chk("fl_idle_plot", dn_plot, 0);
      chk("fl_idle_busy", busy, 0);

      // Asynchronous reset mid-issue
      tick(1, 4'd6, 4'd6, 3'd3, 0, 1);
      tick(0, 4'd0, 4'd0, 3'd0, 0, 1);
      chk("arst_pre_plot", dn_plot, 1);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_plot", dn_plot, 0);
      chk("arst_wreq", cmd_waitrequest, 1);
      chk("arst_count", count, 0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Random traffic against the model
      pend_v = 1'b0;
      pend   = '0;
      for (int k = 0; k < 500; k++) begin
         if (!pend_v && $urandom_range(0, 3) != 0) begin
            pend_v = 1'b1;
            pend   = mcmd_t'($urandom);
         end
         tick(pend_v, pend.x, pend.y, pend.c, $urandom_range(0, 24) == 0,
              $urandom_range(0, 2) == 0);
         if (last_acc) pend_v = 1'b0;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/plot_cmd_queue.md
# plot_cmd_queue

- Responder-side endpoint for cell-plot commands issued by the game control FSM.
- Accepts (x, y, colour) commands on a plot/waitrequest handshake, buffers them in a FIFO and re-issues them in order to the downstream cell plotter using the same handshake as initiator.
- The control FSM fires plot commands without waiting for each cell to be rasterised; it stalls only when the queue is full.

## Interface

Parameters:
- DEPTH, 8: queue entries; power of two, ≥2.
- COLOUR_W, 3: colour width.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cmd_plot  in  1  upstream request; held until accepted.
- cmd_x  in  4  game-grid column.
- cmd_y  in  4  game-grid row.
- cmd_colour  in  COLOUR_W  cell colour.
- cmd_waitrequest  out  1  high = command not accepted this cycle.
- flush  in  1  synchronous queue clear.
- dn_plot  out  1  downstream request (registered).
- dn_x, dn_y  out  4 each  downstream coordinates (registered).
- dn_colour  out  COLOUR_W  downstream colour (registered).
- dn_waitrequest  in  1  downstream stall.
- count  out  $clog2(DEPTH)+1  entries currently queued (in-flight command excluded).
- busy  out  1  count≠0 or downstream command outstanding.

## Operation

- **Upstream acceptance:** cmd_plot && !cmd_waitrequest at a rising edge writes the command into the FIFO.
- **cmd_waitrequest** = rst | flush | (count==DEPTH).
  - Full is judged on registered count only.
  - A pop in the same cycle does not open a slot: no combinational path from dn_waitrequest.
- **Push and pop in the same edge:** count unchanged, pointers both advance.
- **Downstream FSM, states IDLE and ISSUE:**
  - IDLE, count≠0: pop head into dn_* registers, dn_plot←1, go to ISSUE.
  - ISSUE, dn_waitrequest=1: hold dn_plot and dn_x/dn_y/dn_colour stable.
  - ISSUE, dn_waitrequest=0 (accepted), count≠0: pop next entry, dn_plot stays 1, remain in ISSUE (back-to-back, one command per cycle).
  - ISSUE, dn_waitrequest=0, count=0: dn_plot←0, go to IDLE.
- **Ordering:** strict FIFO; no command dropped or duplicated.
- **Flush:**
  - Pointers and count clear at the next edge; any push in that cycle is ignored.
  - The command in flight in ISSUE is not retracted. It completes normally, then the FSM returns to IDLE.
  - If flush coincides with a pop, the pop is suppressed. The current dn_* command is held until accepted, then IDLE.
- **Pointers:** $clog2(DEPTH) bits, natural wrap-around. Count is a separate register, so full and empty are unambiguous.
- **busy** = (count≠0) | (state==ISSUE).

## Timing

- **Reset values** (while rst=1, asynchronously):
  - state IDLE; dn_plot 0; dn_x, dn_y, dn_colour 0; count 0; busy 0; pointers 0; cmd_waitrequest 1.
  - After rst deasserts, cmd_waitrequest=0.
- **Reset mid-operation:** dn_plot falls without waiting for a clock edge; queued commands are lost.
- **Latency:** command accepted at edge E; dn_plot high from edge E+1 when the queue was empty and the FSM was in IDLE.
- **Throughput:** 1 command/cycle on both sides when dn_waitrequest=0.
- **Capacity:** up to DEPTH queued plus 1 in flight.
- **Combinational paths:**
  - cmd_waitrequest depends combinationally only on rst, flush and count.
  - All dn_* outputs come straight from flops.

## Structure

- Shared package snake_pkg holds:
  - GRID_W=4 and COLOUR_W=3.
  - typedef plot_cmd_t, a packed struct {x, y, colour}.
  - typedef for the IDLE/ISSUE enum.
- Sub-module cmd_fifo, a synchronous FIFO of plot_cmd_t with:
  - push, pop, flush inputs;
  - head, count, full, empty outputs;
  - parameter DEPTH.
- The top level holds only the downstream FSM and output registers.

## Test plan

1. **Reset:** hold rst 3 cycles → cmd_waitrequest=1, dn_plot=0, count=0, busy=0; release → cmd_waitrequest=0. Assert rst asynchronously mid-ISSUE → dn_plot=0 immediately.
2. **Single command:**
   - Stimulus: push (1,1,3'b100), dn_waitrequest=0.
   - Response: dn_plot high exactly one cycle, starting one edge after acceptance, carrying 1/1/100; busy falls the following cycle.
3. **Fill and drain:**
   - Stimulus: dn_waitrequest=1; push commands x=0..9.
   - Response: 9 accepted (1 in flight + 8 queued), count=8, cmd_waitrequest=1, 10th held.
   - Then release dn_waitrequest → x=0..9 emerge in order, one per cycle, with no gaps.
4. **Stall hold:**
   - Stimulus: dn_waitrequest high 5 cycles during ISSUE with (9,10,3'b001).
   - Response: dn_plot=1 and dn_x/dn_y/dn_colour stable all 5 cycles.
5. **Simultaneous push/pop:** at count=3, push while a downstream accept occurs → count stays 3, order preserved.
6. **Flush:**
   - Stimulus: 4 queued plus one in flight; pulse flush.
   - Response: count=0 next cycle; in-flight command completes after dn_waitrequest drops; no further dn_plot; a push during flush is ignored.
